// File: rtl/uart_pkg.sv
// uart_pkg: shared enums and parity helper for the UART core.
package uart_pkg;

    typedef enum logic [1:0] {PAR_NONE = 2'd0, PAR_EVEN = 2'd1, PAR_ODD = 2'd2} parity_e;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_e;

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BRK} rx_state_e;

    // Words narrower than 9 bits are zero-extended, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [8:0] data, input parity_e mode);
        return (mode == PAR_ODD) ? ~^data : (mode == PAR_EVEN) ? ^data : 1'b0;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: free-running divider producing the RX oversample enable tick.
module uart_baud_gen #(
    parameter int TICK_DIV = 5
) (
    input  logic clk_i,
    input  logic arst_i,
    output logic tick_o
);

    localparam int W = $clog2(TICK_DIV + 1);

    logic [W-1:0] cnt_q, cnt_d;

    assign tick_o = cnt_q == W'(TICK_DIV - 1);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_core.sv
// uart_core: full-duplex UART with oversampled RX, parity/framing/overrun status.
// Optional internal TX->RX loop enabled by defining UART_LOOPBACK_EN.
module uart_core
    import uart_pkg::*;
#(
    parameter int D_WIDTH     = 8,
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 1_000_000,
    parameter int OVERSAMPLE  = 10,
    parameter int PARITY_MODE = 1,
    parameter int STOP_BITS   = 1
) (
    input  logic               clk_i,
    input  logic               arst_i,
    input  logic [D_WIDTH-1:0] tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic               tx_o,
    input  logic               rx_i,
    output logic [D_WIDTH-1:0] rx_data_o,
    output logic               rx_valid_o,
    input  logic               rx_ready_i,
    output logic               rx_parity_err_o,
    output logic               rx_frame_err_o,
    output logic               rx_overrun_o,
    input  logic               loopback_i
);

    localparam int      BIT_CLKS = CLK_FREQ_HZ / BAUD;
    localparam int      TICK_DIV = BIT_CLKS / OVERSAMPLE;
    localparam int      CNT_W    = $clog2(BIT_CLKS + 1);
    localparam int      IDX_W    = $clog2(D_WIDTH + 1);
    localparam int      TCNT_W   = $clog2(OVERSAMPLE + 1);
    localparam parity_e PAR      = parity_e'(2'(PARITY_MODE));

    if (TICK_DIV < 1 || BIT_CLKS % OVERSAMPLE != 0 || OVERSAMPLE < 4 || OVERSAMPLE % 2 != 0) begin : g_bad_cfg
        $error("uart_core: BIT_CLKS must be a nonzero multiple of an even OVERSAMPLE >= 4");
    end

    logic rx_src;
    logic tx_q, tx_d;

`ifdef UART_LOOPBACK_EN
    assign rx_src = loopback_i ? tx_q : rx_i;
    assign tx_o   = tx_q | loopback_i;
`else
    logic unused_loopback;
    assign unused_loopback = loopback_i;
    assign rx_src = rx_i;
    assign tx_o   = tx_q;
`endif

    tx_state_e          tx_state_q, tx_state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [IDX_W-1:0]   tidx_q, tidx_d;
    logic [D_WIDTH-1:0] tshift_q, tshift_d;
    logic               tpar_q, tpar_d;
    logic               bit_end;

    assign bit_end    = bit_cnt_q == CNT_W'(BIT_CLKS - 1);
    assign tx_ready_o = tx_state_q == TX_IDLE;

    always_comb begin
        tx_state_d = tx_state_q;
        bit_cnt_d  = bit_end ? '0 : bit_cnt_q + 1'b1;
        tidx_d     = tidx_q;
        tshift_d   = tshift_q;
        tpar_d     = tpar_q;
        case (tx_state_q)
            TX_IDLE: begin
                bit_cnt_d = '0;
                if (tx_valid_i) begin
                    tx_state_d = TX_START;
                    tshift_d   = tx_data_i;
                    tpar_d     = calc_parity(9'(tx_data_i), PAR);
                    tidx_d     = '0;
                end
            end
            TX_START: if (bit_end) tx_state_d = TX_DATA;
            TX_DATA: if (bit_end) begin
                tshift_d = tshift_q >> 1;
                tidx_d   = (tidx_q == IDX_W'(D_WIDTH - 1)) ? '0 : tidx_q + 1'b1;
                if (tidx_q == IDX_W'(D_WIDTH - 1)) tx_state_d = (PAR == PAR_NONE) ? TX_STOP : TX_PARITY;
            end
            TX_PARITY: if (bit_end) tx_state_d = TX_STOP;
            TX_STOP: if (bit_end) begin
                tidx_d = tidx_q + 1'b1;
                if (tidx_q == IDX_W'(STOP_BITS - 1)) tx_state_d = TX_IDLE;
            end
            default: tx_state_d = TX_IDLE;
        endcase
        // Line level is registered from the next state so tx has no combinational glitches.
        tx_d = (tx_state_d == TX_START)  ? 1'b0 :
               (tx_state_d == TX_DATA)   ? tshift_d[0] :
               (tx_state_d == TX_PARITY) ? tpar_d : 1'b1;
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            tx_state_q <= TX_IDLE;
            bit_cnt_q  <= '0;
            tidx_q     <= '0;
            tshift_q   <= '0;
            tpar_q     <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            tidx_q     <= tidx_d;
            tshift_q   <= tshift_d;
            tpar_q     <= tpar_d;
            tx_q       <= tx_d;
        end
    end

    logic [1:0] sync_q;
    logic       rx_s, tick;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx_src};
    end

    uart_baud_gen #(.TICK_DIV(TICK_DIV)) u_baud (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .tick_o (tick)
    );

    rx_state_e          rx_state_q, rx_state_d;
    logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
    logic [IDX_W-1:0]   ridx_q, ridx_d;
    logic [D_WIDTH-1:0] rshift_q, rshift_d;
    logic               rpar_q, rpar_d, rferr_q, rferr_d;
    logic               samp, load;

    assign samp = tick && tcnt_q == TCNT_W'(OVERSAMPLE - 1);

    always_comb begin
        rx_state_d = rx_state_q;
        tcnt_d     = tick ? tcnt_q + 1'b1 : tcnt_q;
        ridx_d     = ridx_q;
        rshift_d   = rshift_q;
        rpar_d     = rpar_q;
        rferr_d    = rferr_q;
        load       = 1'b0;
        case (rx_state_q)
            RX_IDLE: if (tick && !rx_s) begin
                rx_state_d = RX_START;
                tcnt_d     = '0;
                rferr_d    = 1'b0;
            end
            RX_START: if (tick && tcnt_q == TCNT_W'(OVERSAMPLE / 2 - 1)) begin
                tcnt_d     = '0;
                ridx_d     = '0;
                rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
            RX_DATA: if (samp) begin
                tcnt_d   = '0;
                rshift_d = {rx_s, rshift_q[D_WIDTH-1:1]};
                ridx_d   = (ridx_q == IDX_W'(D_WIDTH - 1)) ? '0 : ridx_q + 1'b1;
                if (ridx_q == IDX_W'(D_WIDTH - 1)) rx_state_d = (PAR == PAR_NONE) ? RX_STOP : RX_PARITY;
            end
            RX_PARITY: if (samp) begin
                tcnt_d     = '0;
                rpar_d     = rx_s;
                rx_state_d = RX_STOP;
            end
            RX_STOP: if (samp) begin
                tcnt_d  = '0;
                rferr_d = rferr_q | ~rx_s;
                ridx_d  = ridx_q + 1'b1;
                if (ridx_q == IDX_W'(STOP_BITS - 1)) begin
                    load       = 1'b1;
                    rx_state_d = rferr_d ? RX_BRK : RX_IDLE;
                end
            end
            RX_BRK: if (tick && rx_s) rx_state_d = RX_IDLE;
            default: rx_state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rx_state_q <= RX_IDLE;
            tcnt_q     <= '0;
            ridx_q     <= '0;
            rshift_q   <= '0;
            rpar_q     <= 1'b0;
            rferr_q    <= 1'b0;
        end else begin
            rx_state_q <= rx_state_d;
            tcnt_q     <= tcnt_d;
            ridx_q     <= ridx_d;
            rshift_q   <= rshift_d;
            rpar_q     <= rpar_d;
            rferr_q    <= rferr_d;
        end
    end

    logic [D_WIDTH-1:0] data_q, data_d;
    logic               valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
    logic               take;

    // A new word may replace the held one only when the consumer empties it in the same clk.
    assign take    = load && (!valid_q || rx_ready_i);
    assign valid_d = take ? 1'b1 : (valid_q && rx_ready_i) ? 1'b0 : valid_q;
    assign data_d  = take ? rshift_q : data_q;
    assign perr_d  = take ? (PAR != PAR_NONE && rpar_q != calc_parity(9'(rshift_q), PAR)) : perr_q;
    assign ferr_d  = take ? rferr_d : ferr_q;
    assign ovr_d   = load && valid_q && !rx_ready_i;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign rx_data_o       = data_q;
    assign rx_valid_o      = valid_q;
    assign rx_parity_err_o = perr_q;
    assign rx_frame_err_o  = ferr_q;
    assign rx_overrun_o    = ovr_q;

endmodule

// File: tb/tb_uart_core.sv
// tb_uart_core: directed self-checking bench for uart_core at default parameters.
module tb_uart_core;

    logic       clk = 1'b0, arst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0, rx = 1'b1, rx_ready = 1'b1, loopback = 1'b0;
    logic       tx_ready_o, tx_o, rx_valid_o, rx_parity_err_o, rx_frame_err_o, rx_overrun_o;
    logic [7:0] rx_data_o;

    int         n_checks = 0, n_pass = 0;
    int         v_cycles = 0, n_recv = 0, n_ovr = 0;
    logic [7:0] last_data = 8'h00;
    logic       last_perr = 1'b0, last_ferr = 1'b0;

    uart_core dut (
        .clk_i           (clk),
        .arst_i          (arst),
        .tx_data_i       (tx_data),
        .tx_valid_i      (tx_valid),
        .tx_ready_o      (tx_ready_o),
        .tx_o            (tx_o),
        .rx_i            (rx),
        .rx_data_o       (rx_data_o),
        .rx_valid_o      (rx_valid_o),
        .rx_ready_i      (rx_ready),
        .rx_parity_err_o (rx_parity_err_o),
        .rx_frame_err_o  (rx_frame_err_o),
        .rx_overrun_o    (rx_overrun_o),
        .loopback_i      (loopback)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid_o) v_cycles <= v_cycles + 1;
        if (rx_overrun_o) n_ovr <= n_ovr + 1;
        if (rx_valid_o && rx_ready) begin
            n_recv    <= n_recv + 1;
            last_data <= rx_data_o;
            last_perr <= rx_parity_err_o;
            last_ferr <= rx_frame_err_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        logic [10:0] f;
        f = {s, p, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            rx = f[i];
            step(50);
        end
    endtask

    initial begin
        logic [10:0] frame;
        int          low_cnt, b, vb, ob, k;
        repeat (3) @(negedge clk);
        check("rst_tx", tx_o, 1);
        check("rst_tx_ready", tx_ready_o, 1);
        check("rst_rx_valid", rx_valid_o, 0);
        check("rst_rx_data", rx_data_o, 0);
        check("rst_errs", {rx_parity_err_o, rx_frame_err_o, rx_overrun_o}, 0);
        @(posedge clk);
        #2 arst = 1'b0;
        step(5);

        frame   = {1'b1, 1'b0, 8'hA5, 1'b0};
        low_cnt = 0;
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        @(posedge clk);
        #2 tx_valid = 1'b0;
        for (int i = 0; i < 550; i++) begin
            @(negedge clk);
            if (!tx_ready_o) low_cnt++;
            if (i == 0) check("tx_start_first_clk", tx_o, 0);
            if (i == 49) check("tx_start_last_clk", tx_o, 0);
            if (i % 50 == 25) check($sformatf("tx_bit%0d", i / 50), tx_o, frame[i / 50]);
        end
        @(negedge clk);
        check("tx_ready_low_clks", low_cnt, 550);
        check("tx_ready_back", tx_ready_o, 1);
        check("tx_idle_high", tx_o, 1);
        step(10);

        b = n_recv; vb = v_cycles;
        send_frame(8'h3C, 1'b0, 1'b1);
        step(20);
        check("rx_ok_count", n_recv - b, 1);
        check("rx_ok_valid_clks", v_cycles - vb, 1);
        check("rx_ok_data", last_data, 8'h3C);
        check("rx_ok_errs", {last_perr, last_ferr}, 0);

        b = n_recv;
        send_frame(8'h3C, 1'b1, 1'b1);
        step(20);
        check("rx_par_count", n_recv - b, 1);
        check("rx_par_err", last_perr, 1);
        check("rx_par_data", last_data, 8'h3C);

        b = n_recv;
        send_frame(8'h3C, 1'b0, 1'b0);
        step(200);
        check("rx_brk_count", n_recv - b, 1);
        check("rx_brk_ferr", last_ferr, 1);
        check("rx_brk_data", last_data, 8'h3C);
        rx = 1'b1;
        step(100);
        check("rx_brk_no_extra", n_recv - b, 1);
        send_frame(8'h3C, 1'b0, 1'b1);
        step(20);
        check("rx_brk_recover", n_recv - b, 2);
        check("rx_brk_recover_ferr", last_ferr, 0);

        rx_ready = 1'b0;
        b = n_recv; ob = n_ovr;
        send_frame(8'h11, 1'b0, 1'b1);
        step(20);
        send_frame(8'h22, 1'b0, 1'b1);
        step(20);
        @(negedge clk);
        check("ovr_pulses", n_ovr - ob, 1);
        check("ovr_valid_held", rx_valid_o, 1);
        check("ovr_data_kept", rx_data_o, 8'h11);
        step(1);
        rx_ready = 1'b1;
        step(2);
        check("ovr_consume", n_recv - b, 1);
        check("ovr_consume_data", last_data, 8'h11);
        check("ovr_valid_clear", rx_valid_o, 0);

        vb = v_cycles;
        rx = 1'b0;
        step(20);
        rx = 1'b1;
        step(600);
        check("glitch_no_frame", v_cycles - vb, 0);

        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        step(100);
        check("arst_busy_before", tx_ready_o, 0);
        arst = 1'b1;
        #1;
        check("arst_tx_async", tx_o, 1);
        check("arst_ready_async", tx_ready_o, 1);
        step(2);
        arst = 1'b0;
        step(5);
        check("arst_tx_after", tx_o, 1);
        check("arst_rx_valid", rx_valid_o, 0);

`ifdef UART_LOOPBACK_EN
        loopback = 1'b1;
        step(20);
        rx = 1'b0;
        b = n_recv; k = 0; low_cnt = 0;
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        while (n_recv == b && k < 1000) begin
            if (!tx_o) low_cnt++;
            step(1);
            k++;
        end
        check("lb_recv", n_recv - b, 1);
        check("lb_data", last_data, 8'h5A);
        check("lb_perr", last_perr, 0);
        check("lb_tx_forced_high", low_cnt, 0);
        rx = 1'b1;
        step(600);
        loopback = 1'b0;
`else
        loopback = 1'b1;
        b = n_recv;
        send_frame(8'h5A, 1'b0, 1'b1);
        step(20);
        check("nolb_recv", n_recv - b, 1);
        check("nolb_data", last_data, 8'h5A);
        tx_data  = 8'h5A;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
        check("nolb_tx_pin_live", tx_o, 0);
        step(600);
        loopback = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
